// File: rtl/mdu_sequencer_if.sv
// MDU sequencer bus: EX-stage launch/flush/MTHI/MTLO controls
// and HI/LO result, status back to the pipeline.
interface mdu_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cancel;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, cancel,
        output hi_we, lo_we, wdata,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b, cancel,
        input  hi_we, lo_we, wdata,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/mdu_sequencer.sv
// Bit-serial MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
// Magnitude arithmetic in CALC, sign fix-up in a final SIGN cycle.
module mdu_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    mdu_sequencer_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        SIGN
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CW-1:0]    cnt_q;
    logic             div_q;
    logic             neg_q;
    logic             neg_r;
    logic             dz_q;
    logic             done_q;
    logic [WIDTH-1:0] upper_q;
    logic [WIDTH-1:0] lower_q;
    logic [WIDTH-1:0] mag_b_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic             signed_op;
    logic             a_neg;
    logic             b_neg;
    logic             b_zero;
    logic             start_ok;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_sh;
    logic             trial_ok;
    logic [WIDTH-1:0] trial;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    assign signed_op = ~bus.op[0];
    assign a_neg     = signed_op & bus.a[WIDTH-1];
    assign b_neg     = signed_op & bus.b[WIDTH-1];
    assign b_zero    = (bus.b == '0);
    assign a_mag     = a_neg ? -bus.a : bus.a;
    assign b_mag     = b_neg ? -bus.b : bus.b;
    assign start_ok  = (state_q == IDLE) & bus.start & ~bus.cancel;

    assign mul_sum  = {1'b0, upper_q}
                    + (lower_q[0] ? {1'b0, mag_b_q} : '0);
    // Shifted remainder can reach WIDTH+1 bits for large unsigned divisors.
    assign rem_sh   = {upper_q, lower_q[WIDTH-1]};
    assign trial_ok = (rem_sh >= {1'b0, mag_b_q});
    assign trial    = rem_sh[WIDTH-1:0] - mag_b_q;

    assign prod     = {upper_q, lower_q};
    assign prod_fix = neg_q ? -prod : prod;
    assign quo_fix  = (neg_q & ~dz_q) ? -lower_q : lower_q;
    assign rem_fix  = (neg_r & ~dz_q) ? -upper_q : upper_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start_ok) state_d = CALC;
            end
            CALC: begin
                if (bus.cancel)
                    state_d = IDLE;
                else if (cnt_q == CW'(WIDTH - 1))
                    state_d = SIGN;
            end
            SIGN: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            dz_q    <= 1'b0;
            done_q  <= 1'b0;
            upper_q <= '0;
            lower_q <= '0;
            mag_b_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.hi_we) hi_q <= bus.wdata;
                    if (bus.lo_we) lo_q <= bus.wdata;
                    if (start_ok) begin
                        div_q   <= bus.op[1];
                        neg_q   <= a_neg ^ b_neg;
                        neg_r   <= a_neg;
                        dz_q    <= bus.op[1] & b_zero;
                        cnt_q   <= '0;
                        upper_q <= '0;
                        // Divide by zero shifts raw a through to HI.
                        lower_q <= (bus.op[1] & b_zero) ? bus.a : a_mag;
                        mag_b_q <= b_mag;
                    end
                end
                CALC: begin
                    if (!bus.cancel) begin
                        cnt_q <= cnt_q + 1'b1;
                        if (div_q) begin
                            upper_q <= trial_ok ? trial
                                                : rem_sh[WIDTH-1:0];
                            lower_q <= {lower_q[WIDTH-2:0], trial_ok};
                        end else begin
                            upper_q <= mul_sum[WIDTH:1];
                            lower_q <= {mul_sum[0], lower_q[WIDTH-1:1]};
                        end
                    end
                end
                SIGN: begin
                    if (!bus.cancel) begin
                        done_q <= 1'b1;
                        if (div_q) begin
                            hi_q <= rem_fix;
                            lo_q <= quo_fix;
                        end else begin
                            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                            lo_q <= prod_fix[WIDTH-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = done_q;
    assign bus.div_zero = dz_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
endmodule

// File: tb/tb_mdu_sequencer.sv
// Scoreboard bench for mdu_sequencer: directed corner cases plus
// randomized ops against a plain-arithmetic reference model.
module tb_mdu_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    mdu_sequencer_if #(.WIDTH(32)) bus();

    mdu_sequencer #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [64:0] sb[$];
    logic [31:0] mhi;
    logic [31:0] mlo;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Returns {div_zero, hi, lo}
    function automatic logic [64:0] model(input logic [1:0] o,
                                          input logic [31:0] x,
                                          input logic [31:0] y);
        longint sx;
        longint sy;
        logic [63:0] t;
        logic [63:0] q;
        logic [63:0] r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            2'b00: begin
                t = sx * sy;
                return {1'b0, t};
            end
            2'b01: begin
                t = {32'b0, x} * {32'b0, y};
                return {1'b0, t};
            end
            2'b10: begin
                if (y == 0) return {1'b1, x, 32'hFFFF_FFFF};
                q = sx / sy;
                r = sx % sy;
                return {1'b0, r[31:0], q[31:0]};
            end
            default: begin
                if (y == 0) return {1'b1, x, 32'hFFFF_FFFF};
                return {1'b0, x % y, x / y};
            end
        endcase
    endfunction

    task automatic run_op(input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input int poke,
                          input int cancel_at);
        logic [64:0] e;
        int n;
        int bc;
        e = model(o, x, y);
        bus.start = 1'b1;
        bus.op    = o;
        bus.a     = x;
        bus.b     = y;
        if (cancel_at == 0) begin
            sb.push_back(e);
            mhi = e[63:32];
            mlo = e[31:0];
        end
        n  = 0;
        bc = 0;
        do begin
            @(negedge clk);
            n++;
            if (bus.busy) bc++;
            bus.hi_we  = 1'b0;
            bus.lo_we  = 1'b0;
            bus.start  = (n == poke);
            if (n == poke) begin
                bus.op = ~o;
                bus.a  = ~x;
                bus.b  = y + 32'd1;
            end
            bus.cancel = (n == cancel_at);
        end while (!bus.done && n < 40 &&
                   !(cancel_at > 0 && n > cancel_at));
        if (cancel_at > 0) begin
            chk("cancel_busy_low", bus.busy, 0);
        end else begin
            chk("done_latency", n, 34);
            chk("busy_cycles", bc, 33);
        end
    endtask

    task automatic wr(input logic hw, input logic lw,
                      input logic [31:0] d);
        bus.hi_we = hw;
        bus.lo_we = lw;
        bus.wdata = d;
        @(negedge clk);
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        if (hw) mhi = d;
        if (lw) mlo = d;
        chk("mt_hi", bus.hi, mhi);
        chk("mt_lo", bus.lo, mlo);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [64:0] e;
        bus.start  = 1'b0;
        bus.op     = 2'b00;
        bus.a      = '0;
        bus.b      = '0;
        bus.cancel = 1'b0;
        bus.hi_we  = 1'b0;
        bus.lo_we  = 1'b0;
        bus.wdata  = '0;
        mhi = '0;
        mlo = '0;

        fork
            forever begin
                @(negedge clk);
                if (bus.done) begin
                    chk("busy_with_done", bus.busy, 0);
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: got done=1 required 0");
                    end else begin
                        e = sb.pop_front();
                        chk("res_hi", bus.hi, e[63:32]);
                        chk("res_lo", bus.lo, e[31:0]);
                        chk("res_dz", bus.div_zero, e[64]);
                    end
                end
            end
        join_none

        #12;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_dz", bus.div_zero, 0);
        chk("rst_hi", bus.hi, 0);
        chk("rst_lo", bus.lo, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        chk("multu_max_hi", bus.hi, 32'hFFFF_FFFE);
        chk("multu_max_lo", bus.lo, 32'h0000_0001);
        run_op(2'b00, -32'sd3, 32'd5, 0, 0);
        chk("mult_neg_lo", bus.lo, 32'hFFFF_FFF1);
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 0, 0);
        chk("mult_min_hi", bus.hi, 32'h4000_0000);
        run_op(2'b10, -32'sd7, 32'd2, 0, 0);
        chk("div_neg_lo", bus.lo, 32'hFFFF_FFFD);
        chk("div_neg_hi", bus.hi, 32'hFFFF_FFFF);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        chk("div_ovf_lo", bus.lo, 32'h8000_0000);
        chk("div_ovf_hi", bus.hi, 32'h0);
        run_op(2'b11, 32'd7, 32'd0, 0, 0);
        chk("divz_flag", bus.div_zero, 1);
        chk("divz_hi", bus.hi, 32'd7);
        run_op(2'b11, 32'd100, 32'd7, 0, 0);
        chk("b2b_lo", bus.lo, 32'd14);
        chk("b2b_hi", bus.hi, 32'd2);
        chk("b2b_dz", bus.div_zero, 0);

        wr(1'b1, 1'b0, 32'h1234);
        run_op(2'b01, 32'd6, 32'd7, 0, 10);
        repeat (5) @(negedge clk);
        chk("cancel_hi", bus.hi, 32'h1234);
        chk("cancel_lo", bus.lo, mlo);

        run_op(2'b11, 32'd1000, 32'd9, 5, 0);
        chk("ignored_start_lo", bus.lo, 32'd111);

        bus.start = 1'b1;
        bus.op    = 2'b10;
        bus.a     = 32'd5;
        bus.b     = 32'd0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        chk("dz_before_rst", bus.div_zero, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_hi", bus.hi, 0);
        chk("mid_rst_lo", bus.lo, 0);
        chk("mid_rst_dz", bus.div_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;
        mhi = '0;
        mlo = '0;
        @(negedge clk);
        run_op(2'b01, 32'd2, 32'd3, 0, 0);
        chk("post_rst_lo", bus.lo, 32'd6);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                wr(1'($urandom_range(0, 1)), 1'b1, $urandom);
            end
            bus.hi_we = ($urandom_range(0, 3) == 0);
            bus.lo_we = ($urandom_range(0, 3) == 0);
            bus.wdata = $urandom;
            run_op(2'($urandom_range(0, 3)), pick(), pick(), 0, 0);
        end

        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
